// File: rtl/blink_scheduler.sv
// Tick generator and toggle-enable sequencer for a bank of N_CH blinker cells.
// Each tick emits one-cycle enables in all-on, round-robin or binary-count order.
module blink_scheduler #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 24,
  parameter int DEF_PERIOD = 1000
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [1:0]       cfg_mode,
  output logic             tick_o,
  output logic [N_CH-1:0]  en_o,
  output logic             busy_o
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       mode_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [N_CH-1:0]  tcnt_reg;
  logic             tick_reg;
  logic [N_CH-1:0]  en_reg;

  logic             cfg_take;
  logic [CNT_W-1:0] cfg_period_eff;
  logic [N_CH-1:0]  rr_pattern;
  logic [N_CH-1:0]  bin_pattern;
  logic [N_CH-1:0]  pattern;

  // State register
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run)  state_next = RUN;
      RUN:     if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register
  always_comb begin
    busy_o    = (state_reg == RUN);
    cfg_ready = (state_reg == IDLE);
  end

  assign cfg_take       = cfg_valid && cfg_ready;
  assign cfg_period_eff = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

  always_comb begin
    rr_pattern          = '0;
    rr_pattern[ptr_reg] = 1'b1;
  end

  // Bit i toggles when all lower bits of the tick count are ones (binary carry)
  assign bin_pattern[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < N_CH; gi++) begin : g_bin
      assign bin_pattern[gi] = &tcnt_reg[gi-1:0];
    end
  endgenerate

  always_comb begin
    pattern = '0;
    case (mode_reg)
      2'b01:   pattern = '1;
      2'b10:   pattern = rr_pattern;
      2'b11:   pattern = bin_pattern;
      default: pattern = '0;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      period_reg <= CNT_W'(DEF_PERIOD);
      mode_reg   <= 2'b01;
      cnt_reg    <= CNT_W'(DEF_PERIOD - 1);
      ptr_reg    <= '0;
      tcnt_reg   <= '0;
      tick_reg   <= 1'b0;
      en_reg     <= '0;
    end else if (state_reg == IDLE || !run) begin
      // Idle, or leaving RUN: a tick due on the stop edge is dropped
      tick_reg <= 1'b0;
      en_reg   <= '0;
      ptr_reg  <= '0;
      tcnt_reg <= '0;
      if (cfg_take) begin
        period_reg <= cfg_period_eff;
        mode_reg   <= cfg_mode;
        cnt_reg    <= cfg_period_eff - CNT_W'(1);
      end else begin
        cnt_reg <= period_reg - CNT_W'(1);
      end
    end else if (cnt_reg == '0) begin
      cnt_reg  <= period_reg - CNT_W'(1);
      tick_reg <= 1'b1;
      en_reg   <= pattern;
      ptr_reg  <= (ptr_reg == PTR_W'(N_CH - 1)) ? '0 : ptr_reg + PTR_W'(1);
      tcnt_reg <= tcnt_reg + N_CH'(1);
    end else begin
      cnt_reg  <= cnt_reg - CNT_W'(1);
      tick_reg <= 1'b0;
      en_reg   <= '0;
    end
  end

  assign tick_o = tick_reg;
  assign en_o   = en_reg;

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler: tick spacing, enable patterns, config
// handshake stalls, simultaneous run/config, and mid-run reset.
module tb_blink_scheduler;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 24;
  localparam int DEF_PERIOD = 1000;

  logic             system1000 = 1'b0;
  logic             system1000_rst;
  logic             run;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [1:0]       cfg_mode;
  logic             tick_o;
  logic [N_CH-1:0]  en_o;
  logic             busy_o;

  int   checks   = 0;
  int   failures = 0;
  logic ready_seen;
  int   n;
  int   bin_exp [8] = '{1, 3, 1, 7, 1, 3, 1, 15};

  blink_scheduler #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .system1000    (system1000),
    .system1000_rst(system1000_rst),
    .run           (run),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_mode      (cfg_mode),
    .tick_o        (tick_o),
    .en_o          (en_o),
    .busy_o        (busy_o)
  );

  always #5 system1000 = ~system1000;

  task automatic step();
    @(posedge system1000);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Steps until tick_o is seen; returns the number of cycles waited, -1 on timeout
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
      if (cfg_ready) ready_seen = 1'b1;
    end while (!tick_o && cycles < 5000);
    if (!tick_o) cycles = -1;
    $display("tick after %0d cycles en=%b busy=%b", cycles, en_o, busy_o);
  endtask

  task automatic offer_cfg(input int p, input logic [1:0] m);
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_mode   = m;
    step();
    cfg_valid  = 1'b0;
    $display("config period=%0d mode=%b", p, m);
  endtask

  initial begin
    system1000_rst = 1'b1;
    run            = 1'b0;
    cfg_valid      = 1'b0;
    cfg_period     = '0;
    cfg_mode       = 2'b00;
    ready_seen     = 1'b0;
    repeat (2) step();
    system1000_rst = 1'b0;
    step();
    check("rst_busy",  32'(busy_o),    0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_tick",  32'(tick_o),    0);
    check("rst_en",    32'(en_o),      0);

    // Default period, mode all
    run = 1'b1;
    step();
    check("run_busy",  32'(busy_o),    1);
    check("run_ready", 32'(cfg_ready), 0);
    ready_seen = 1'b0;
    wait_tick(n);
    check("def_first_dist", 32'(n), 1000);
    check("def_first_en",   32'(en_o), 15);
    wait_tick(n);
    check("def_second_dist", 32'(n), 1000);
    check("def_second_en",   32'(en_o), 15);
    check("def_ready_in_run", 32'(ready_seen), 0);

    run = 1'b0;
    step();
    check("stop_busy", 32'(busy_o), 0);
    check("stop_tick", 32'(tick_o), 0);
    check("stop_en",   32'(en_o),   0);

    // Round-robin, period 3
    offer_cfg(3, 2'b10);
    run = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      wait_tick(n);
      check("rr_dist", 32'(n), 3);
      check("rr_en",   32'(en_o), 32'(1 << (k % 4)));
    end

    // Binary count, period 0 stored as 1
    run = 1'b0;
    step();
    offer_cfg(0, 2'b11);
    run = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      wait_tick(n);
      check("bin_dist", 32'(n), 1);
      check("bin_en",   32'(en_o), 32'(bin_exp[k % 8]));
    end

    // Offer held during RUN is stalled; old period and mode persist
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(5);
    cfg_mode   = 2'b01;
    ready_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      check("stall_dist", 32'(n), 1);
      check("stall_en",   32'(en_o), 32'(bin_exp[k]));
    end
    check("stall_ready", 32'(ready_seen), 0);
    run = 1'b0;
    step();
    check("stall_stop_ready", 32'(cfg_ready), 1);
    check("stall_stop_tick",  32'(tick_o),    0);
    check("stall_stop_en",    32'(en_o),      0);
    step();
    cfg_valid = 1'b0;
    run       = 1'b1;
    step();
    wait_tick(n);
    check("stall_new_dist", 32'(n), 5);
    check("stall_new_en",   32'(en_o), 15);
    wait_tick(n);
    check("stall_new_dist2", 32'(n), 5);

    // Simultaneous run and config in IDLE
    run = 1'b0;
    step();
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(2);
    cfg_mode   = 2'b00;
    run        = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("simul_busy", 32'(busy_o), 1);
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      check("simul_dist", 32'(n), 2);
      check("simul_en",   32'(en_o), 0);
    end

    // Reset on the edge where the next tick is due, with run and an offer active
    step();
    system1000_rst = 1'b1;
    cfg_valid      = 1'b1;
    cfg_period     = CNT_W'(7);
    cfg_mode       = 2'b10;
    step();
    check("mrst_tick",  32'(tick_o),    0);
    check("mrst_en",    32'(en_o),      0);
    check("mrst_busy",  32'(busy_o),    0);
    check("mrst_ready", 32'(cfg_ready), 1);
    system1000_rst = 1'b0;
    cfg_valid      = 1'b0;
    run            = 1'b0;
    step();
    check("mrst_hold_busy",  32'(busy_o),    0);
    check("mrst_hold_ready", 32'(cfg_ready), 1);
    check("mrst_hold_tick",  32'(tick_o),    0);

    // tcnt must restart from zero after reset
    offer_cfg(1, 2'b11);
    run = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      check("mrst_bin_en", 32'(en_o), 32'(bin_exp[k]));
    end

    // Period and mode return to defaults after reset
    run            = 1'b0;
    system1000_rst = 1'b1;
    step();
    system1000_rst = 1'b0;
    step();
    run = 1'b1;
    step();
    wait_tick(n);
    check("mrst_def_dist", 32'(n), 1000);
    check("mrst_def_en",   32'(en_o), 15);
    run = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
